// File: rtl/devinatkin_pwm_if.sv
// Configuration/output bus of the eight-channel PWM block.
// The controller side drives ui_in and observes uo_out.
interface devinatkin_pwm_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  modport master (output ui_in, input uo_out);
  modport slave  (input ui_in, output uo_out);
endinterface

// File: rtl/devinatkin_pwm.sv
// Eight-channel 4-bit PWM with a shared prescaled 16-step counter.
// Duty writes land in a shadow bank and are promoted to the active bank only at period wrap.
module devinatkin_pwm #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  devinatkin_pwm_if.slave         bus
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [15:0] prescaler;
  logic [3:0]  cnt;
  logic [3:0]  shadow_duty [8];
  logic [3:0]  active_duty [8];
  logic [7:0]  uo_q;

  logic        tick;
  logic        wrap;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [3:0]  wr_duty;

  assign tick    = (prescaler == PS_LAST);
  assign wrap    = tick && (cnt == 4'd15);
  assign wr_en   = bus.ui_in[7];
  assign wr_sel  = bus.ui_in[6:4];
  assign wr_duty = bus.ui_in[3:0];

  // rst_n is active-high here; reset wins over any concurrent write.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      prescaler <= '0;
      cnt       <= '0;
      uo_q      <= '0;
      for (int n = 0; n < 8; n++) begin
        shadow_duty[n] <= '0;
        active_duty[n] <= '0;
      end
    end else begin
      prescaler <= tick ? '0 : prescaler + 16'd1;
      if (tick) cnt <= cnt + 4'd1;

      if (wr_en) shadow_duty[wr_sel] <= wr_duty;

      // Active bank takes the pre-write shadow, so a write on the wrap edge waits a period.
      if (wrap) begin
        for (int n = 0; n < 8; n++) active_duty[n] <= shadow_duty[n];
      end

      for (int n = 0; n < 8; n++) uo_q[n] <= (cnt < active_duty[n]);
    end
  end

  assign bus.uo_out = uo_q;

endmodule

// File: tb/tb_devinatkin_pwm.sv
// Directed bench for devinatkin_pwm: one instance at PRESCALE=1, one at PRESCALE=3.
module tb_devinatkin_pwm;

  logic clk;
  logic rst_n;

  devinatkin_pwm_if if1 ();
  devinatkin_pwm_if if3 ();

  devinatkin_pwm #(.PRESCALE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  devinatkin_pwm #(.PRESCALE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int k;
  int first3;
  int hi1 [8];
  int hi3 [8];
  logic [3:0] exp1 [8];
  logic [3:0] exp3 [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (k=%0d)", tag, got, want, k);
    end
  endtask

  task automatic reset_counts();
    for (int b = 0; b < 8; b++) begin
      hi1[b] = 0;
      hi3[b] = 0;
    end
    first3 = -1;
  endtask

  // Counter phase before edge k is closed-form: (k-1)%16 for PRESCALE=1, ((k-1)/3)%16 for 3.
  task automatic cycles(input int n);
    logic [3:0] c1, c3;
    logic [7:0] e1, e3;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      k++;
      c1 = 4'((k - 1) % 16);
      c3 = 4'(((k - 1) / 3) % 16);
      for (int b = 0; b < 8; b++) begin
        e1[b] = (c1 < exp1[b]);
        e3[b] = (c3 < exp3[b]);
      end
      chk("uo1", 32'(if1.uo_out), 32'(e1));
      chk("uo3", 32'(if3.uo_out), 32'(e3));
      for (int b = 0; b < 8; b++) begin
        hi1[b] += int'(if1.uo_out[b]);
        hi3[b] += int'(if3.uo_out[b]);
      end
      if (if3.uo_out[2] === 1'b1 && first3 < 0) first3 = k;
    end
  endtask

  task automatic do_reset(input int n, input logic [7:0] ui);
    rst_n = 1'b1;
    if1.ui_in = ui;
    if3.ui_in = ui;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_uo1", 32'(if1.uo_out), 32'h0);
      chk("rst_uo3", 32'(if3.uo_out), 32'h0);
    end
    rst_n = 1'b0;
    if1.ui_in = 8'h00;
    if3.ui_in = 8'h00;
    k = 0;
    for (int b = 0; b < 8; b++) begin
      exp1[b] = 4'd0;
      exp3[b] = 4'd0;
    end
    reset_counts();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    k = 0;
    rst_n = 1'b1;
    if1.ui_in = 8'h00;
    if3.ui_in = 8'h00;
    for (int b = 0; b < 8; b++) begin
      exp1[b] = 4'd0;
      exp3[b] = 4'd0;
    end
    reset_counts();

    // Reset with a write asserted: the write must be ignored.
    do_reset(3, 8'hFF);
    cycles(32);
    for (int b = 0; b < 8; b++) chk("idle_hi1", 32'(hi1[b]), 32'd0);

    // ch0 = 4; wrap edges for PRESCALE=1 are k = 16, 32, 48, ...
    if1.ui_in = 8'h84; cycles(1);
    if1.ui_in = 8'h00; cycles(15);
    exp1[0] = 4'd4;
    reset_counts(); cycles(16);
    chk("basic_hi_ch0", 32'(hi1[0]), 32'd4);
    chk("basic_hi_ch1", 32'(hi1[1]), 32'd0);
    chk("basic_hi_ch7", 32'(hi1[7]), 32'd0);

    // All channels: ch n = 2n+1.
    for (int n = 0; n < 8; n++) begin
      if1.ui_in = {1'b1, 3'(n), 4'(2 * n + 1)};
      cycles(1);
    end
    if1.ui_in = 8'h00; cycles(8);
    for (int n = 0; n < 8; n++) exp1[n] = 4'(2 * n + 1);
    reset_counts(); cycles(1);
    chk("all_rise", 32'(if1.uo_out), 32'hFF);
    cycles(15);
    for (int n = 0; n < 8; n++) chk("all_hi", 32'(hi1[n]), 32'(2 * n + 1));

    // Boundary duties on ch3.
    if1.ui_in = 8'hB0; cycles(1);
    if1.ui_in = 8'h00; cycles(15);
    exp1[3] = 4'd0;
    reset_counts(); cycles(16);
    chk("d0_hi_ch3", 32'(hi1[3]), 32'd0);
    if1.ui_in = 8'hBF; cycles(1);
    if1.ui_in = 8'h00; cycles(15);
    exp1[3] = 4'd15;
    reset_counts(); cycles(16);
    chk("d15_hi_ch3", 32'(hi1[3]), 32'd15);

    // Double buffer: ch1 = 8, then 2 written mid-period.
    if1.ui_in = 8'h98; cycles(1);
    if1.ui_in = 8'h00; cycles(15);
    exp1[1] = 4'd8;
    reset_counts(); cycles(5);
    if1.ui_in = 8'h92; cycles(1);
    if1.ui_in = 8'h00; cycles(10);
    chk("dbuf_cur_ch1", 32'(hi1[1]), 32'd8);
    exp1[1] = 4'd2;
    reset_counts(); cycles(16);
    chk("dbuf_next_ch1", 32'(hi1[1]), 32'd2);

    // Write on the wrap edge (k=224) applies one period later.
    cycles(15);
    if1.ui_in = 8'h96; cycles(1);
    if1.ui_in = 8'h00;
    reset_counts(); cycles(16);
    chk("wrapwr_hold_ch1", 32'(hi1[1]), 32'd2);
    exp1[1] = 4'd6;
    reset_counts(); cycles(16);
    chk("wrapwr_new_ch1", 32'(hi1[1]), 32'd6);

    // Pending write to ch5 discarded by a mid-period reset.
    if1.ui_in = 8'hD9; cycles(1);
    if1.ui_in = 8'h00; cycles(3);
    do_reset(2, 8'h00);

    // PRESCALE=3: ch2 = 5, wraps at k = 48, 96.
    if3.ui_in = 8'hA5; cycles(1);
    if3.ui_in = 8'h00; cycles(47);
    exp3[2] = 4'd5;
    reset_counts(); cycles(48);
    chk("ps3_hi_ch2", 32'(hi3[2]), 32'd15);
    chk("ps3_lo_ch2", 32'(48 - hi3[2]), 32'd33);
    chk("ps3_first_rise", 32'(first3), 32'd49);
    chk("ps3_hi_ch0", 32'(hi3[0]), 32'd0);
    chk("discard_hi_ch5", 32'(hi1[5]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
